// File: rtl/base_station_ho.sv
// Base-station handover controller: serves a device, watches its link
// quality and hands it over to a peer station when quality stays low.
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   peer_target_in        - peers naming this station as handover target
//   dm_sq                 - link quality reported by the device
//   dm_target_valid/dm_target - device's proposed best station
//   sv_data               - server payload
//   dm_respond/dm_request - serving flag / request for a better station
//   dm_data               - payload forwarded to the device
//   peer_target_out       - one-hot handover notification to peers
//   sv_target/sv_target_valid - new serving station reported to server
//   ho_fail               - aborted handover strobe
module base_station_ho #(
    parameter int NUM_BS    = 3,
    parameter int BS_ID     = 1,
    parameter int SQ_W      = 8,
    parameter int SQ_THRESH = 50,
    parameter int HYST      = 3,
    parameter int TIMEOUT   = 8,
    parameter int DATA_W    = 8,
    localparam int ID_W     = (NUM_BS > 1) ? $clog2(NUM_BS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_BS-1:0] peer_target_in,
    input  logic [SQ_W-1:0]   dm_sq,
    input  logic              dm_target_valid,
    input  logic [ID_W-1:0]   dm_target,
    input  logic [DATA_W-1:0] sv_data,
    output logic              dm_respond,
    output logic              dm_request,
    output logic [DATA_W-1:0] dm_data,
    output logic [NUM_BS-1:0] peer_target_out,
    output logic [ID_W-1:0]   sv_target,
    output logic              sv_target_valid,
    output logic              ho_fail
);

    localparam int HC_W = (HYST > 0) ? $clog2(HYST + 1) : 1;
    localparam int WC_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [HC_W-1:0]   HYST_C = HC_W'(HYST);
    localparam logic [WC_W-1:0]   TO_C   = WC_W'(TIMEOUT);
    localparam logic [SQ_W-1:0]   SQ_LIM = SQ_W'(SQ_THRESH);
    localparam logic [ID_W-1:0]   SELF   = ID_W'(BS_ID);
    localparam logic [ID_W:0]     NB_C   = (ID_W + 1)'(NUM_BS);
    localparam logic [NUM_BS-1:0] SELF_M = NUM_BS'(1) << BS_ID;

    typedef enum logic [2:0] {
        IDLE,
        TARGET,
        SOURCE,
        CHECK_SQ,
        NOTIFY_BS,
        NOTIFY_SV
    } state_t;

    state_t          state;
    logic [HC_W-1:0] lo_cnt;
    logic [HC_W-1:0] lo_next;
    logic [WC_W-1:0] wait_cnt;
    logic [WC_W-1:0] wait_next;
    logic [ID_W-1:0] tgt;
    logic            peer_hit;
    logic            tgt_ok;

    // Our own bit in peer_target_in is meaningless and masked off.
    assign peer_hit  = |(peer_target_in & ~SELF_M);
    assign tgt_ok    = {1'b0, dm_target} < NB_C;
    assign wait_next = wait_cnt + WC_W'(1);

    // Low-quality run length, saturating at HYST.
    always_comb begin
        lo_next = '0;
        if (dm_sq < SQ_LIM) begin
            lo_next = (lo_cnt == HYST_C) ? lo_cnt : lo_cnt + HC_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            lo_cnt          <= '0;
            wait_cnt        <= '0;
            tgt             <= '0;
            dm_respond      <= 1'b0;
            dm_request      <= 1'b0;
            dm_data         <= '0;
            peer_target_out <= '0;
            sv_target       <= '0;
            sv_target_valid <= 1'b0;
            ho_fail         <= 1'b0;
        end else begin
            sv_target_valid <= 1'b0;
            ho_fail         <= 1'b0;
            unique case (state)
                IDLE: begin
                    dm_respond <= peer_hit;
                    if (peer_hit) state <= TARGET;
                end
                TARGET: begin
                    dm_respond <= 1'b1;
                    state      <= SOURCE;
                end
                SOURCE: begin
                    dm_respond      <= 1'b1;
                    dm_data         <= sv_data;
                    peer_target_out <= '0;
                    lo_cnt          <= lo_next;
                    if (lo_next == HYST_C) begin
                        state      <= CHECK_SQ;
                        dm_request <= 1'b1;
                        wait_cnt   <= '0;
                    end
                end
                CHECK_SQ: begin
                    // A valid answer wins over a timeout in the same cycle.
                    if (dm_target_valid) begin
                        dm_request <= 1'b0;
                        wait_cnt   <= '0;
                        lo_cnt     <= '0;
                        if (dm_target == SELF) begin
                            state <= SOURCE;
                        end else if (!tgt_ok) begin
                            state   <= SOURCE;
                            ho_fail <= 1'b1;
                        end else begin
                            tgt             <= dm_target;
                            peer_target_out <= NUM_BS'(1) << dm_target;
                            dm_respond      <= 1'b0;
                            state           <= NOTIFY_BS;
                        end
                    end else if (wait_next == TO_C) begin
                        state      <= SOURCE;
                        ho_fail    <= 1'b1;
                        dm_request <= 1'b0;
                        wait_cnt   <= '0;
                        lo_cnt     <= '0;
                    end else begin
                        wait_cnt <= wait_next;
                    end
                end
                NOTIFY_BS: begin
                    peer_target_out <= '0;
                    sv_target       <= tgt;
                    sv_target_valid <= 1'b1;
                    state           <= NOTIFY_SV;
                end
                NOTIFY_SV: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_base_station_ho.sv
// Testbench for base_station_ho: directed handover scenarios plus
// randomized traffic compared every cycle against a behavioural model.
module tb_base_station_ho;

    localparam int NUM_BS    = 3;
    localparam int BS_ID     = 1;
    localparam int SQ_THRESH = 50;
    localparam int HYST      = 3;
    localparam int TIMEOUT   = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] peer_target_in = '0;
    logic [7:0] dm_sq = 8'd100;
    logic       dm_target_valid = 1'b0;
    logic [1:0] dm_target = '0;
    logic [7:0] sv_data = '0;
    logic       dm_respond;
    logic       dm_request;
    logic [7:0] dm_data;
    logic [2:0] peer_target_out;
    logic [1:0] sv_target;
    logic       sv_target_valid;
    logic       ho_fail;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    base_station_ho #(
        .NUM_BS(NUM_BS), .BS_ID(BS_ID), .SQ_W(8), .SQ_THRESH(SQ_THRESH),
        .HYST(HYST), .TIMEOUT(TIMEOUT), .DATA_W(8)
    ) dut (
        .clk(clk), .reset(reset), .peer_target_in(peer_target_in),
        .dm_sq(dm_sq), .dm_target_valid(dm_target_valid),
        .dm_target(dm_target), .sv_data(sv_data),
        .dm_respond(dm_respond), .dm_request(dm_request),
        .dm_data(dm_data), .peer_target_out(peer_target_out),
        .sv_target(sv_target), .sv_target_valid(sv_target_valid),
        .ho_fail(ho_fail)
    );

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: who is serving, how long quality has been poor,
    // whether we are asking the device, and which notification is pending.
    int serving, fresh, asking, low_run, waited, notify, chosen;
    int e_resp, e_req, e_data, e_pout, e_svt, e_svv, e_fail;

    task automatic model_step();
        int t;
        e_fail = 0;
        e_svv  = 0;
        if (reset) begin
            serving = 0; fresh = 0; asking = 0; low_run = 0;
            waited = 0; notify = 0; chosen = 0;
            e_resp = 0; e_req = 0; e_data = 0; e_pout = 0; e_svt = 0;
        end else if (notify == 1) begin
            notify = 2;
            e_pout = 0;
            e_svt  = chosen;
            e_svv  = 1;
        end else if (notify == 2) begin
            notify = 0;
        end else if (serving == 0) begin
            if ((int'(peer_target_in) & ~(1 << BS_ID)) != 0) begin
                serving = 1;
                fresh   = 1;
                e_resp  = 1;
            end else begin
                e_resp = 0;
            end
        end else if (fresh != 0) begin
            fresh = 0;
        end else if (asking == 0) begin
            e_data  = int'(sv_data);
            low_run = (int'(dm_sq) < SQ_THRESH) ? low_run + 1 : 0;
            if (low_run >= HYST) begin
                asking = 1;
                waited = 0;
                e_req  = 1;
            end
        end else if (dm_target_valid) begin
            t       = int'(dm_target);
            asking  = 0;
            low_run = 0;
            e_req   = 0;
            if (t >= NUM_BS) begin
                e_fail = 1;
            end else if (t != BS_ID) begin
                chosen  = t;
                serving = 0;
                notify  = 1;
                e_pout  = 1 << t;
                e_resp  = 0;
            end
        end else begin
            waited++;
            if (waited == TIMEOUT) begin
                asking  = 0;
                low_run = 0;
                e_req   = 0;
                e_fail  = 1;
            end
        end
    endtask

    always @(posedge clk) begin
        model_step();
        #2;
        check("dm_respond", 32'(dm_respond), 32'(e_resp));
        check("dm_request", 32'(dm_request), 32'(e_req));
        check("dm_data", 32'(dm_data), 32'(e_data));
        check("peer_target_out", 32'(peer_target_out), 32'(e_pout));
        check("sv_target", 32'(sv_target), 32'(e_svt));
        check("sv_target_valid", 32'(sv_target_valid), 32'(e_svv));
        check("ho_fail", 32'(ho_fail), 32'(e_fail));
    end

    task automatic step(int n = 1);
        repeat (n) @(negedge clk);
    endtask

    // From IDLE: get named as target, then three low samples reach CHECK_SQ.
    task automatic to_check();
        peer_target_in = 3'b001;
        dm_sq = 8'd0;
        step();
        peer_target_in = '0;
        step(4);
        check("enter_check_req", 32'(dm_request), 32'd1);
    endtask

    initial begin
        int sq_seq[5] = '{40, 40, 60, 40, 40};

        step(2);
        check("rst_resp", 32'(dm_respond), 32'd0);
        check("rst_pout", 32'(peer_target_out), 32'd0);
        check("rst_data", 32'(dm_data), 32'd0);
        reset = 1'b0;

        sv_data = 8'hA5;
        peer_target_in = 3'b001;
        dm_sq = 8'd100;
        step();
        check("target_resp", 32'(dm_respond), 32'd1);
        peer_target_in = '0;
        step();
        check("source_resp", 32'(dm_respond), 32'd1);
        step();
        check("source_data", 32'(dm_data), 32'hA5);

        foreach (sq_seq[i]) begin
            dm_sq = 8'(sq_seq[i]);
            step();
            check("hyst_no_req", 32'(dm_request), 32'd0);
        end
        dm_sq = 8'd40;
        step();
        check("hyst_req", 32'(dm_request), 32'd1);

        dm_target_valid = 1'b1;
        dm_target = 2'd2;
        step();
        dm_target_valid = 1'b0;
        check("nbs_pout", 32'(peer_target_out), 32'b100);
        check("nbs_resp", 32'(dm_respond), 32'd0);
        check("nbs_req", 32'(dm_request), 32'd0);
        step();
        check("nsv_target", 32'(sv_target), 32'd2);
        check("nsv_valid", 32'(sv_target_valid), 32'd1);
        check("nsv_pout", 32'(peer_target_out), 32'd0);
        step();
        check("idle_valid", 32'(sv_target_valid), 32'd0);
        check("idle_resp", 32'(dm_respond), 32'd0);

        to_check();
        step(7);
        check("to_wait_fail", 32'(ho_fail), 32'd0);
        check("to_wait_req", 32'(dm_request), 32'd1);
        step();
        check("to_fail", 32'(ho_fail), 32'd1);
        check("to_req", 32'(dm_request), 32'd0);
        check("to_resp", 32'(dm_respond), 32'd1);
        step(3);
        check("recheck_req", 32'(dm_request), 32'd1);
        step(7);
        dm_target_valid = 1'b1;
        dm_target = 2'd0;
        step();
        dm_target_valid = 1'b0;
        check("late_pout", 32'(peer_target_out), 32'b001);
        check("late_fail", 32'(ho_fail), 32'd0);
        step(2);

        to_check();
        dm_target_valid = 1'b1;
        dm_target = 2'd1;
        step();
        dm_target_valid = 1'b0;
        check("self_req", 32'(dm_request), 32'd0);
        check("self_resp", 32'(dm_respond), 32'd1);
        check("self_fail", 32'(ho_fail), 32'd0);
        check("self_pout", 32'(peer_target_out), 32'd0);
        step(3);
        dm_target_valid = 1'b1;
        dm_target = 2'd3;
        step();
        dm_target_valid = 1'b0;
        check("bad_fail", 32'(ho_fail), 32'd1);
        check("bad_req", 32'(dm_request), 32'd0);

        step(3);
        dm_target_valid = 1'b1;
        dm_target = 2'd2;
        step();
        dm_target_valid = 1'b0;
        check("pre_rst_pout", 32'(peer_target_out), 32'b100);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid_rst_pout", 32'(peer_target_out), 32'd0);
        check("mid_rst_resp", 32'(dm_respond), 32'd0);
        check("mid_rst_svt", 32'(sv_target), 32'd0);
        check("mid_rst_data", 32'(dm_data), 32'd0);
        step();
        check("post_rst_svv", 32'(sv_target_valid), 32'd0);

        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 199) == 0);
            peer_target_in = ($urandom_range(0, 3) == 0) ?
                3'($urandom_range(0, 7)) : 3'd0;
            dm_sq = 8'($urandom_range(0, 99));
            dm_target_valid = ($urandom_range(0, 4) == 0);
            dm_target = 2'($urandom_range(0, 3));
            sv_data = 8'($urandom);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/base_station_ho.md
BASE_STATION_HO -- requirements
Module: base_station_ho

Interface
REQ-001 SHALL have parameter NUM_BS, default 3: number of base stations in the cell cluster, minimum 2.
REQ-002 SHALL have parameter BS_ID, default 1: this station's index, 0..NUM_BS-1.
REQ-003 SHALL have parameter SQ_W, default 8: signal-quality width.
REQ-004 SHALL have parameter SQ_THRESH, default 50: handover threshold, unsigned.
REQ-005 SHALL have parameter HYST, default 3: consecutive low-SQ cycles required before handover, minimum 1.
REQ-006 SHALL have parameter TIMEOUT, default 8: maximum cycles waiting for a device-manager answer.
REQ-007 SHALL have parameter DATA_W, default 8: payload width.
REQ-008 SHALL define localparam ID_W = $clog2(NUM_BS), minimum 1.
REQ-009 SHALL have port clk, input, 1: the single clock.
REQ-010 SHALL have port reset, input, 1: synchronous, active-high.
REQ-011 SHALL have port peer_target_in, input, NUM_BS: bit k high means peer k names this BS as target; bit BS_ID is ignored.
REQ-012 SHALL have port dm_sq, input, SQ_W: current link quality reported by the device.
REQ-013 SHALL have port dm_target_valid, input, 1: dm_target is valid this cycle.
REQ-014 SHALL have port dm_target, input, ID_W: best BS index proposed by the device.
REQ-015 SHALL have port sv_data, input, DATA_W: server payload.
REQ-016 SHALL have port dm_respond, output, 1: this BS serves the device.
REQ-017 SHALL have port dm_request, output, 1: this BS asks the device for a better BS.
REQ-018 SHALL have port dm_data, output, DATA_W: payload forwarded to the device.
REQ-019 SHALL have port peer_target_out, output, NUM_BS: one-hot handover notification to peers; bit BS_ID is always 0.
REQ-020 SHALL have port sv_target, output, ID_W: new serving BS reported to the server.
REQ-021 SHALL have port sv_target_valid, output, 1: one-cycle strobe qualifying sv_target.
REQ-022 SHALL have port ho_fail, output, 1: one-cycle strobe indicating an aborted handover.

Function
REQ-023 SHALL register all outputs; an output change appears one clk edge after the state or condition that causes it.
REQ-024 SHALL implement the states IDLE, TARGET, SOURCE, CHECK_SQ, NOTIFY_BS and NOTIFY_SV.
REQ-025 IDLE SHALL go to TARGET if any peer_target_in bit other than BS_ID is set; otherwise it SHALL stay in IDLE with dm_respond=0.
REQ-026 TARGET SHALL last one cycle, set dm_respond=1 and go to SOURCE.
REQ-027 SOURCE SHALL drive dm_respond=1, dm_data=sv_data and peer_target_out=0.
REQ-028 In SOURCE, a low-SQ counter SHALL increment on each cycle with dm_sq<SQ_THRESH, clear when dm_sq>=SQ_THRESH, and saturate at HYST.
REQ-029 In SOURCE, the FSM SHALL go to CHECK_SQ in the cycle the counter reaches HYST.
REQ-030 CHECK_SQ SHALL hold dm_request=1, dm_respond=1 and count wait cycles.
REQ-031 In CHECK_SQ, on dm_target_valid with dm_target==BS_ID, the FSM SHALL return to SOURCE, clear the counters, drop dm_request and raise no fail strobe.
REQ-032 In CHECK_SQ, on dm_target_valid with dm_target>=NUM_BS, the FSM SHALL return to SOURCE and pulse ho_fail.
REQ-033 In CHECK_SQ, on dm_target_valid with any other index, the FSM SHALL latch the index and go to NOTIFY_BS.
REQ-034 In CHECK_SQ, if the wait count reaches TIMEOUT without a valid answer, the FSM SHALL return to SOURCE, pulse ho_fail and clear the counters.
REQ-035 When dm_target_valid arrives in the same cycle the wait count reaches TIMEOUT, the FSM SHALL take the valid answer.
REQ-036 NOTIFY_BS SHALL last one cycle, set peer_target_out bit[latched]=1 with all others 0, and set dm_request=0 and dm_respond=0.
REQ-037 NOTIFY_SV SHALL last one cycle, set sv_target=latched, pulse sv_target_valid, clear peer_target_out and go to IDLE.
REQ-038 peer_target_in SHALL be ignored in every state except IDLE.
REQ-039 dm_data SHALL hold its last value outside SOURCE.

Reset
REQ-040 On reset the FSM SHALL enter IDLE on the next edge.
REQ-041 On reset all outputs, counters and the latched target SHALL clear to 0; reset SHALL take priority over any in-flight state.

Verification
REQ-042 Parameters NUM_BS=3, BS_ID=1: peer_target_in=3'b001 in IDLE -> TARGET, then SOURCE; dm_respond=1 on both cycles; dm_data follows sv_data=8'hA5.
REQ-043 In SOURCE, dm_sq=40,40,60,40,40,40 -> no CHECK_SQ until the 3rd consecutive low sample; dm_request=1 on the following cycle.
REQ-044 In CHECK_SQ, valid with dm_target=2 -> peer_target_out=3'b100 for 1 cycle, then sv_target=2 with sv_target_valid pulse, then IDLE with dm_respond=0.
REQ-045 In CHECK_SQ, no valid for 8 cycles -> ho_fail pulse, return to SOURCE, dm_request=0; valid arriving on cycle 8 -> handover taken and no ho_fail.
REQ-046 In CHECK_SQ, dm_target=1 -> stay serving with no strobes; dm_target=3 -> ho_fail pulse.
REQ-047 Reset asserted during NOTIFY_BS -> next cycle in IDLE with all outputs 0.
